// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: memory-side controller for the data cache.
// Dirty-line evictions go into a small circular write buffer. Cache refills
// are served from backing memory, or forwarded straight from the buffer when
// a buffered eviction matches. Buffered writes drain when memory is idle.
//
// Optional feature macro: WB_COALESCE_EN
//   defined   : a push to the word address of a valid, non-frozen entry
//               overwrites that entry's data instead of allocating.
//   undefined : every push allocates; forwarding returns the youngest match.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data  eviction write offer; wb_ready = can accept
//   refill_req/refill_addr    refill request, held until refill_ready
//   refill_valid/refill_data  one-cycle refill response
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_ack/mem_rdata         memory completion and read data
module cache_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wb_valid,
    input  logic [DATA_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    input  logic                  refill_req,
    input  logic [DATA_WIDTH-1:0] refill_addr,
    output logic                  refill_ready,
    output logic                  refill_valid,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = DATA_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state;
    logic [AW-1:0]         buf_addr [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic [AW-1:0]         wb_word;
    logic [AW-1:0]         rf_word;
    logic                  push;
    logic                  alloc;
    logic                  pop;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] head_data;
    logic [PTR_W-1:0]      idx;
    logic                  unused_bits;

    assign unused_bits = ^{wb_addr[1:0], refill_addr[1:0]};

    assign full    = (count == CNT_W'(DEPTH));
    assign wb_word = wb_addr[DATA_WIDTH-1:2];
    assign rf_word = refill_addr[DATA_WIDTH-1:2];

`ifdef WB_COALESCE_EN
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;
`endif

    // Scan valid entries oldest to youngest so later matches win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
`ifdef WB_COALESCE_EN
        coal_hit = 1'b0;
        coal_idx = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (buf_addr[idx] == rf_word) begin
                    fwd_hit  = 1'b1;
                    fwd_data = buf_data[idx];
                end
`ifdef WB_COALESCE_EN
                if (buf_addr[idx] == wb_word && !(state == WRITE && idx == head)) begin
                    coal_hit = 1'b1;
                    coal_idx = idx;
                end
`endif
            end
        end
    end

`ifdef WB_COALESCE_EN
    assign wb_ready = !full || coal_hit;
    assign push     = wb_valid && wb_ready;
    assign alloc    = push && !coal_hit;
    // A coalescing push into the head in the same cycle the drain starts must
    // reach mem_wdata, otherwise the new data would be popped unseen.
    assign head_data = (push && coal_hit && coal_idx == head) ? wb_data : buf_data[head];
`else
    assign wb_ready  = !full;
    assign push      = wb_valid && wb_ready;
    assign alloc     = push;
    assign head_data = buf_data[head];
`endif

    assign refill_ready = (state == IDLE) && !full;
    assign pop          = (state == WRITE) && mem_ack;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
            end
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            refill_valid <= 1'b0;
            refill_data  <= '0;
        end else begin
            if (alloc) begin
                buf_addr[tail] <= wb_word;
                buf_data[tail] <= wb_data;
                tail           <= tail + PTR_W'(1);
            end
`ifdef WB_COALESCE_EN
            if (push && coal_hit) begin
                buf_data[coal_idx] <= wb_data;
            end
`endif
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (full || (!refill_req && count != '0)) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {buf_addr[head], 2'b00};
                        mem_wdata <= head_data;
                    end else if (refill_req) begin
                        // The same-cycle push is the youngest candidate.
                        if (push && wb_word == rf_word) begin
                            refill_data  <= wb_data;
                            refill_valid <= 1'b1;
                            state        <= RESP;
                        end else if (fwd_hit) begin
                            refill_data  <= fwd_data;
                            refill_valid <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state    <= READ;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {rf_word, 2'b00};
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        refill_data  <= mem_rdata;
                        refill_valid <= 1'b1;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RESP: begin
                    refill_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: directed scenarios followed by a
// randomized phase. Expected refill data comes from a coherence model (the
// most recent accepted eviction to a word, else backing memory contents).
module tb_cache_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_addr, wb_data;
    logic        refill_req, refill_ready, refill_valid;
    logic [31:0] refill_addr, refill_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cache_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .refill_req(refill_req), .refill_addr(refill_addr), .refill_ready(refill_ready),
        .refill_valid(refill_valid), .refill_data(refill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model state
    logic [31:0] last_wr [int unsigned];
    logic [31:0] mem     [int unsigned];
    typedef struct { logic [31:0] data; int acc; } exp_t;
    exp_t        exp_q[$];
    logic [63:0] wq[$];
    logic [31:0] wlog[$];
    int          rd_ack_cyc   = -1;
    int          acks_allowed = -1;
    int          ack_lat      = 0;
    int          wait_cnt     = 0;
    bit          rand_lat     = 0;

    function automatic logic [31:0] init_val(input int unsigned w);
        return (w * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] mem_read(input int unsigned w);
        return mem.exists(w) ? mem[w] : init_val(w);
    endfunction

    function automatic logic [31:0] expected_for(input int unsigned w);
        return last_wr.exists(w) ? last_wr[w] : mem_read(w);
    endfunction

    // Backing memory: acks after ack_lat waiting cycles, limited by acks_allowed.
    always @(negedge CLK) begin
        mem_ack = 1'b0;
        if (RST && mem_req && acks_allowed != 0) begin
            if (wait_cnt >= ack_lat) begin
                int unsigned w;
                w = int'(mem_addr[31:2]);
                check("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (acks_allowed > 0) acks_allowed--;
                if (mem_we) begin
                    mem[w] = mem_wdata;
                    wlog.push_back(mem_wdata);
`ifndef WB_COALESCE_EN
                    if (wq.size() == 0) fail_now("write_unexpected");
                    else begin
                        logic [63:0] e;
                        e = wq.pop_front();
                        check("write_addr", mem_addr, e[63:32]);
                        check("write_data", mem_wdata, e[31:0]);
                    end
`endif
                end else begin
                    mem_rdata = mem_read(w);
                    if (exp_q.size() != 0) rd_ack_cyc = cyc;
                end
                if (rand_lat) ack_lat = int'($urandom_range(0, 3));
            end else begin
                wait_cnt++;
            end
        end
    end

    // Scoreboard: record handshakes, compare refill responses.
    always @(negedge CLK) begin
        if (RST) begin
            if (refill_valid) begin
                if (exp_q.size() == 0) fail_now("refill_unexpected");
                else begin
                    exp_t e;
                    int   want;
                    e    = exp_q.pop_front();
                    want = (rd_ack_cyc >= 0) ? rd_ack_cyc + 1 : e.acc + 1;
                    check("refill_data", refill_data, e.data);
                    check("refill_latency", 32'(cyc), 32'(want));
                end
            end
            if (wb_valid && wb_ready) begin
                last_wr[int'(wb_addr[31:2])] = wb_data;
                wq.push_back({wb_addr[31:2], 2'b00, wb_data});
            end
            if (refill_req && refill_ready) begin
                exp_q.push_back('{data: expected_for(int'(refill_addr[31:2])), acc: cyc});
                rd_ack_cyc = -1;
            end
        end
    end

    task automatic wb_push(input logic [31:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (wb_ready) begin
                @(posedge CLK); #1;
                wb_valid = 1'b0;
                return;
            end
        end
        fail_now("wb_push_timeout");
        wb_valid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] a);
        refill_req = 1'b1; refill_addr = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (refill_ready) begin
                @(posedge CLK); #1;
                refill_req = 1'b0;
                return;
            end
        end
        fail_now("refill_timeout");
        refill_req = 1'b0;
    endtask

    task automatic wait_refill_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (refill_valid) return;
        end
        fail_now("refill_valid_timeout");
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if (!mem_req && exp_q.size() == 0 && !refill_valid) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                @(posedge CLK); #1;
                return;
            end
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        RST = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        refill_req = 1'b0; refill_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge CLK);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_refill_valid", {31'b0, refill_valid}, 32'h0);
        check("rst_refill_data", refill_data, 32'h0);
        check("rst_wb_ready", {31'b0, wb_ready}, 32'h1);
        check("rst_refill_ready", {31'b0, refill_ready}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Forward from buffer: refill presented right after the push.
        wb_push(32'h100, 32'hAAAA0001);
        refill(32'h100);
        @(negedge CLK);
        check("fwd_valid", {31'b0, refill_valid}, 32'h1);
        check("fwd_data", refill_data, 32'hAAAA0001);
        check("fwd_no_mem_req", {31'b0, mem_req}, 32'h0);
        wait_quiet();

        // Refill from memory with a 3-cycle wait.
        mem[32'h200 >> 2] = 32'h12345678;
        ack_lat = 3;
        refill(32'h201);
        @(negedge CLK);
        check("rd_mem_req", {31'b0, mem_req}, 32'h1);
        check("rd_mem_we", {31'b0, mem_we}, 32'h0);
        check("rd_mem_addr", mem_addr, 32'h200);
        wait_refill_valid();
        check("rd_data", refill_data, 32'h12345678);
        ack_lat = 0;
        wait_quiet();

        // Fill the buffer with memory stalled.
        acks_allowed = 0;
        wb_push(32'h500, 32'h5000);
        wb_push(32'h504, 32'h5004);
        wb_push(32'h508, 32'h5008);
        wb_push(32'h50C, 32'h500C);
        @(negedge CLK);
        check("full_wb_ready", {31'b0, wb_ready}, 32'h0);
        check("full_refill_ready", {31'b0, refill_ready}, 32'h0);
        check("full_mem_we", {31'b0, mem_we}, 32'h1);
        check("full_mem_addr", mem_addr, 32'h500);
        acks_allowed = 1;
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge CLK);
                if (mem_ack) seen = 1;
            end
            if (!seen) fail_now("full_ack_timeout");
        end
        @(negedge CLK);
        check("pop_wb_ready", {31'b0, wb_ready}, 32'h1);
        acks_allowed = -1;
        wait_quiet();

        // Same-cycle push and refill to one address.
        wb_valid = 1'b1; wb_addr = 32'h300; wb_data = 32'h0000BEEF;
        refill_req = 1'b1; refill_addr = 32'h300;
        @(negedge CLK);
        check("same_hs", {30'b0, wb_ready, refill_ready}, 32'h3);
        @(posedge CLK); #1;
        wb_valid = 1'b0; refill_req = 1'b0;
        @(negedge CLK);
        check("same_valid", {31'b0, refill_valid}, 32'h1);
        check("same_data", refill_data, 32'h0000BEEF);
        wait_quiet();

        // Back-to-back pushes to one address.
        acks_allowed = 0;
        wlog.delete();
        wb_push(32'h400, 32'h1);
        wb_push(32'h400, 32'h2);
        acks_allowed = -1;
        wait_quiet();
`ifdef WB_COALESCE_EN
        check("coal_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) check("coal_wdata", wlog[0], 32'h2);
`else
        check("dup_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check("dup_wdata0", wlog[0], 32'h1);
            check("dup_wdata1", wlog[1], 32'h2);
        end
`endif

        // Reset in the middle of a stalled write with two entries buffered.
        acks_allowed = 0;
        wb_push(32'h600, 32'h6000);
        wb_push(32'h604, 32'h6004);
        @(negedge CLK);
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'h1);
        #2 RST = 1'b0;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'h0);
        check("arst_mem_we", {31'b0, mem_we}, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_wb_ready", {31'b0, wb_ready}, 32'h1);
        check("arst_refill_ready", {31'b0, refill_ready}, 32'h1);
        last_wr.delete(); wq.delete(); exp_q.delete(); wait_cnt = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        acks_allowed = -1;
        wlog.delete();
        repeat (10) @(negedge CLK);
        check("post_rst_writes", 32'(wlog.size()), 32'd0);
        check("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
        @(posedge CLK); #1;

        // Randomized traffic over a small address set.
        rand_lat = 1;
        for (int n = 0; n < 600; n++) begin
            bit wb_acc, rf_acc;
            @(negedge CLK);
            wb_acc = wb_valid && wb_ready;
            rf_acc = refill_req && refill_ready;
            @(posedge CLK); #1;
            if (!wb_valid || wb_acc) begin
                wb_valid = ($urandom_range(0, 1) == 1);
                wb_addr  = 32'h700 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
                wb_data  = $urandom;
            end
            if (!refill_req || rf_acc) begin
                refill_req  = ($urandom_range(0, 3) == 0);
                refill_addr = 32'h700 + 4 * $urandom_range(0, 6) + $urandom_range(0, 3);
            end
        end
        @(negedge CLK);
        begin
            bit wb_acc, rf_acc;
            wb_acc = wb_valid && wb_ready;
            rf_acc = refill_req && refill_ready;
            @(posedge CLK); #1;
            if (wb_acc) wb_valid = 1'b0;
            if (rf_acc) refill_req = 1'b0;
        end
        while (wb_valid || refill_req) begin
            bit wb_acc, rf_acc;
            @(negedge CLK);
            wb_acc = wb_valid && wb_ready;
            rf_acc = refill_req && refill_ready;
            @(posedge CLK); #1;
            if (wb_acc) wb_valid = 1'b0;
            if (rf_acc) refill_req = 1'b0;
        end
        wait_quiet();
        foreach (last_wr[w]) check("final_mem", mem_read(w), last_wr[w]);
`ifndef WB_COALESCE_EN
        check("final_wq_empty", 32'(wq.size()), 32'd0);
`endif
        check("final_no_pending_refill", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
